// File: rtl/log2_frac_iter.sv
// ---------------------------------------------------------------------------
// log2_frac_iter
//
// Purpose:
//   Iterative binary logarithm of a normalised mantissa. The operand is a
//   Q1.(W-1) value in [1,2). The block produces the NBITS fraction bits of
//   log2(operand), one bit per clock, by repeated squaring. Squaring doubles
//   the logarithm, so the integer bit that spills out of each square is the
//   next fraction bit. When that bit is 1 the square is renormalised back
//   into [1,2).
//
//   Configuration macro LOG2_ROUND_EN:
//     undefined (default) - the result is truncated after NBITS squares.
//     defined             - one extra guard square is run. Its bit is added
//                           to the result (round half-up), and the sum
//                           saturates at all-ones.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   operand present on in_mant
//   in_ready   block is idle and will take an operand
//   in_mant    operand mantissa, MSB is the integer bit (must be 1)
//   out_valid  out_frac / out_err hold a result
//   out_ready  consumer takes the result
//   out_frac   log2 fraction, MSB has weight 2^-1
//   out_err    operand was illegal (integer bit was 0)
// ---------------------------------------------------------------------------
module log2_frac_iter #(
    parameter int W     = 8,
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_mant,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_frac,
    output logic             out_err
);

`ifdef LOG2_ROUND_EN
    localparam int STEPS = NBITS + 1;
`else
    localparam int STEPS = NBITS;
`endif
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SQUARE,
        DONE
    } state_t;

    state_t             state, state_next;
    logic [W-1:0]       m, m_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic [NBITS-1:0]   frac, frac_next;
    logic               err, err_next;

    logic [2*W-1:0]     prod;
    logic               sq_bit;
    logic [W-1:0]       sq_m;
    logic               last_step;

    // Full-width square of the running mantissa. The product is Q2.(2W-2).
    // Its top bit tells whether the square reached [2,4).
    assign prod      = {{W{1'b0}}, m} * {{W{1'b0}}, m};
    assign sq_bit    = prod[2*W-1];
    assign sq_m      = sq_bit ? prod[2*W-1:W] : prod[2*W-2:W-1];
    assign last_step = (cnt == CW'(STEPS - 1));

    // State and datapath registers. Reset clears everything immediately,
    // which aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            m     <= '0;
            cnt   <= '0;
            frac  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            m     <= m_next;
            cnt   <= cnt_next;
            frac  <= frac_next;
            err   <= err_next;
        end
    end

    // Next-state and datapath logic.
    //
    // An illegal operand still passes through one SQUARE cycle so that
    // out_valid rises one edge after acceptance. The err flag makes that
    // cycle a pass-through: no squaring and no bit emission.
    always_comb begin
        state_next = state;
        m_next     = m;
        cnt_next   = cnt;
        frac_next  = frac;
        err_next   = err;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    cnt_next   = '0;
                    frac_next  = '0;
                    state_next = SQUARE;
                    if (in_mant[W-1]) begin
                        m_next   = in_mant;
                        err_next = 1'b0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            SQUARE: begin
                if (err) begin
                    state_next = DONE;
                end else begin
                    m_next   = sq_m;
                    cnt_next = cnt + 1'b1;
`ifdef LOG2_ROUND_EN
                    // The final square yields the guard bit. It is added,
                    // not shifted in, and the sum is held at all-ones.
                    if (last_step) begin
                        if (sq_bit && (frac != {NBITS{1'b1}}))
                            frac_next = frac + 1'b1;
                    end else begin
                        frac_next = (frac << 1) | NBITS'(sq_bit);
                    end
`else
                    frac_next = (frac << 1) | NBITS'(sq_bit);
`endif
                    if (last_step)
                        state_next = DONE;
                end
            end

            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_frac  = frac;
    assign out_err   = err;

endmodule
